// File: rtl/inst_decode_queue.sv
// inst_decode_queue: buffered MIPS instruction decoder.
// Instruction words are decoded on the input side. The decoded records are held
// in a DEPTH-entry FIFO between fetch and ID/EX.
// Optional feature macro: INST_DECODE_QUEUE_PERF_EN builds the pop counters
// perf_issued and perf_rtype. When it is not defined, both ports are tied to 0.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both high. Ready never depends on valid from the other party.
// in_ready comes from registered occupancy only, so it ignores out_ready.
// flush has priority over any transfer in the same cycle.
module inst_decode_queue #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_inst,
  input  logic [PC_WIDTH-1:0]        in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic [5:0]                 out_opcode,
  output logic [4:0]                 out_rs,
  output logic [4:0]                 out_rt,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_shamt,
  output logic [5:0]                 out_funct,
  output logic [15:0]                out_imm16,
  output logic [25:0]                out_jt,
  output logic [31:0]                out_imm_ext,
  output logic [1:0]                 out_class,
  output logic [$clog2(DEPTH):0]     count,
  output logic [31:0]                perf_issued,
  output logic [31:0]                perf_rtype
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  localparam logic [1:0] CLASS_R = 2'd0;
  localparam logic [1:0] CLASS_J = 2'd1;
  localparam logic [1:0] CLASS_I = 2'd2;

  // Decoded record storage, one slot per entry.
  logic [PC_WIDTH-1:0] pc_mem    [DEPTH];
  logic [31:0]         inst_mem  [DEPTH];
  logic [31:0]         imm_mem   [DEPTH];
  logic [1:0]          class_mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic [5:0]  in_opcode;
  logic [15:0] in_imm16;
  logic [1:0]  in_class;
  logic [31:0] in_imm_ext;
  logic        push;
  logic        pop;

  assign in_opcode = in_inst[31:26];
  assign in_imm16  = in_inst[15:0];

  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Input-side decode: instruction class and the extended immediate.
  always_comb begin
    in_class   = CLASS_I;
    in_imm_ext = {{16{in_imm16[15]}}, in_imm16};
    case (in_opcode)
      6'h00:        in_class = CLASS_R;
      6'h02, 6'h03: in_class = CLASS_J;
      default:      in_class = CLASS_I;
    endcase
    case (in_opcode)
      6'h0C, 6'h0D, 6'h0E: in_imm_ext = {16'h0000, in_imm16};
      6'h0F:               in_imm_ext = {in_imm16, 16'h0000};
      default:             in_imm_ext = {{16{in_imm16[15]}}, in_imm16};
    endcase
  end

  // Record storage. It is cleared on reset so the head never reads as X.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        inst_mem[i]  <= '0;
        imm_mem[i]   <= '0;
        class_mem[i] <= '0;
      end
    end else if (push && !flush) begin
      pc_mem[wr_ptr]    <= in_pc;
      inst_mem[wr_ptr]  <= in_inst;
      imm_mem[wr_ptr]   <= in_imm_ext;
      class_mem[wr_ptr] <= in_class;
    end
  end

  // Pointer and occupancy bookkeeping. flush overrides push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The head entry drives every output field.
  always_comb begin
    out_pc      = pc_mem[rd_ptr];
    out_opcode  = inst_mem[rd_ptr][31:26];
    out_rs      = inst_mem[rd_ptr][25:21];
    out_rt      = inst_mem[rd_ptr][20:16];
    out_rd      = inst_mem[rd_ptr][15:11];
    out_shamt   = inst_mem[rd_ptr][10:6];
    out_funct   = inst_mem[rd_ptr][5:0];
    out_imm16   = inst_mem[rd_ptr][15:0];
    out_jt      = inst_mem[rd_ptr][25:0];
    out_imm_ext = imm_mem[rd_ptr];
    out_class   = class_mem[rd_ptr];
  end

`ifdef INST_DECODE_QUEUE_PERF_EN
  logic [31:0] issued_q;
  logic [31:0] rtype_q;

  // Pop counters. They survive flush and wrap naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issued_q <= '0;
      rtype_q  <= '0;
    end else if (pop && !flush) begin
      issued_q <= issued_q + 32'd1;
      if (out_class == CLASS_R) rtype_q <= rtype_q + 32'd1;
    end
  end

  assign perf_issued = issued_q;
  assign perf_rtype  = rtype_q;
`else
  assign perf_issued = 32'd0;
  assign perf_rtype  = 32'd0;
`endif

endmodule

// File: tb/tb_inst_decode_queue.sv
// Directed testbench for inst_decode_queue (DEPTH=4, PC_WIDTH=32).
module tb_inst_decode_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [4:0]  out_shamt;
  logic [5:0]  out_funct;
  logic [15:0] out_imm16;
  logic [25:0] out_jt;
  logic [31:0] out_imm_ext;
  logic [1:0]  out_class;
  logic [2:0]  count;
  logic [31:0] perf_issued;
  logic [31:0] perf_rtype;

  inst_decode_queue #(.DEPTH(DEPTH), .PC_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_shamt(out_shamt), .out_funct(out_funct), .out_imm16(out_imm16),
    .out_jt(out_jt), .out_imm_ext(out_imm_ext), .out_class(out_class),
    .count(count), .perf_issued(perf_issued), .perf_rtype(perf_rtype)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard: {inst, pc} of entries expected in the queue, oldest first
  logic [63:0] exp_q[$];
  int          m_count;
  int          m_issued;
  int          m_rtype;
  int          total;
  int          bad;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the perf ports against the pop model (or against 0 when the counters are not built).
  task automatic check_perf();
`ifdef INST_DECODE_QUEUE_PERF_EN
    check("perf_issued", 64'(perf_issued), 64'(m_issued));
    check("perf_rtype", 64'(perf_rtype), 64'(m_rtype));
`else
    check("perf_issued", 64'(perf_issued), 64'd0);
    check("perf_rtype", 64'(perf_rtype), 64'd0);
`endif
  endtask

  // One clock with the inputs as currently driven. The model is updated and checked.
  task automatic tick();
    logic [63:0] head;
    bit push_ok;
    bit pop_ok;
    push_ok = in_valid && (m_count != DEPTH);
    pop_ok  = out_ready && (m_count != 0);
    if (pop_ok) begin
      head = exp_q[0];
      check("head_pc", 64'(out_pc), 64'(head[31:0]));
      check("head_inst", 64'({out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct}),
            64'(head[63:32]));
    end
    if (flush) begin
      exp_q.delete();
      m_count = 0;
    end else begin
      if (pop_ok) begin
        head = exp_q.pop_front();
        m_count--;
        m_issued++;
        if (head[63:58] == 6'h00) m_rtype++;
      end
      if (push_ok) begin
        exp_q.push_back({in_inst, in_pc});
        m_count++;
      end
    end
    @(posedge clk);
    #1;
    check("count", 64'(count), 64'(m_count));
    check("out_valid", 64'(out_valid), 64'(m_count != 0));
    check("in_ready", 64'(in_ready), 64'(m_count != DEPTH));
    check_perf();
  endtask

  // Driver tasks
  task automatic push_word(input logic [31:0] inst, input logic [31:0] pc);
    in_inst   = inst;
    in_pc     = pc;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic pop_word();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] gen_inst(input int k);
    logic [31:0] w;
    if (k % 2 == 0) w = 32'h0000_0020 | (32'(k) << 11);
    else            w = 32'h2000_0000 | 32'(k);
    return w;
  endfunction

  int k;

  initial begin
    total = 0; bad = 0;
    m_count = 0; m_issued = 0; m_rtype = 0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_pc", 64'(out_pc), 64'd0);
    check("rst_imm_ext", 64'(out_imm_ext), 64'd0);
    check("rst_jt", 64'(out_jt), 64'd0);
    check("rst_class", 64'(out_class), 64'd0);
    check_perf();
    reset = 1'b0;

    // R-type ADD $8,$9,$10
    push_word(32'h012A4020, 32'h00400000);
    check("add_pc", 64'(out_pc), 64'h00400000);
    check("add_opcode", 64'(out_opcode), 64'h0);
    check("add_rs", 64'(out_rs), 64'd9);
    check("add_rt", 64'(out_rt), 64'd10);
    check("add_rd", 64'(out_rd), 64'd8);
    check("add_shamt", 64'(out_shamt), 64'd0);
    check("add_funct", 64'(out_funct), 64'h20);
    check("add_class", 64'(out_class), 64'd0);
    pop_word();

    // ADDI: sign-extended immediate
    push_word(32'h2008FFFF, 32'h00400004);
    check("addi_opcode", 64'(out_opcode), 64'h08);
    check("addi_rt", 64'(out_rt), 64'd8);
    check("addi_imm16", 64'(out_imm16), 64'hFFFF);
    check("addi_imm_ext", 64'(out_imm_ext), 64'hFFFFFFFF);
    check("addi_class", 64'(out_class), 64'd2);
    pop_word();

    // ORI: zero-extended immediate
    push_word(32'h3508FFFF, 32'h00400008);
    check("ori_opcode", 64'(out_opcode), 64'h0D);
    check("ori_imm_ext", 64'(out_imm_ext), 64'h0000FFFF);
    check("ori_class", 64'(out_class), 64'd2);
    pop_word();

    // LUI: immediate shifted into the upper half
    push_word(32'h3C011234, 32'h0040000C);
    check("lui_rt", 64'(out_rt), 64'd1);
    check("lui_imm_ext", 64'(out_imm_ext), 64'h12340000);
    pop_word();

    // JAL: jump class and target
    push_word(32'h0C100000, 32'h00400010);
    check("jal_opcode", 64'(out_opcode), 64'h03);
    check("jal_class", 64'(out_class), 64'd1);
    check("jal_jt", 64'(out_jt), 64'h0100000);
    pop_word();

    // Fill to DEPTH with the consumer stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_inst = gen_inst(i);
      in_pc   = 32'h1000 + 32'(i) * 4;
      tick();
    end
    check("full_count", 64'(count), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    // A fifth offer is refused while full
    in_inst = gen_inst(DEPTH);
    in_pc   = 32'h1000 + 32'(DEPTH) * 4;
    tick();
    check("full_hold_count", 64'(count), 64'd4);

    // Streaming with both sides active. Each word is held until it is accepted.
    k = DEPTH;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bit acc;
      in_inst = gen_inst(k);
      in_pc   = 32'h1000 + 32'(k) * 4;
      acc = (m_count != DEPTH);
      tick();
      total++;
      assert (count == 3'd3 || count == 3'd4) else begin
        bad++;
        $error("FAIL stream_count_range observed=%0d expected=3..4", count);
      end
      if (acc) k++;
    end
    check("stream_count", 64'(count), 64'd3);

    // Flush together with push and pop. flush wins.
    in_inst   = 32'hFFFF_FFFF;
    in_pc     = 32'hBAD0_0000;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    tick();

    // The next word after the flush is at the head. The flushed word is gone.
    push_word(32'h3C01BEEF, 32'hDEAD0000);
    check("post_flush_pc", 64'(out_pc), 64'hDEAD0000);
    check("post_flush_imm", 64'(out_imm_ext), 64'hBEEF0000);
    pop_word();
    check_perf();

    // Asynchronous reset in the middle of a cycle
    push_word(32'h012A4020, 32'h00500000);
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    m_count = 0; m_issued = 0; m_rtype = 0;
    check("arst_count", 64'(count), 64'd0);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_out_pc", 64'(out_pc), 64'd0);
    check_perf();
    @(negedge clk);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_decode_queue.md
Name: inst_decode_queue

Overview:
- Buffered, parametrised MIPS instruction decoder placed between instruction fetch and the ID/EX stage, and mirrored in the debugger.
- Accepts tagged instruction words over a valid/ready handshake and splits each word into fields. Also computes the class and the extended immediate.
- Holds decoded entries in a DEPTH-entry FIFO, so fetch can run ahead of a stalled downstream stage.
- A flush input discards all buffered entries on branch redirect.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- PC_WIDTH, 32, width of the PC tag carried with each instruction.

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous clear of all buffered entries
- in_valid  input  1  an instruction word is offered
- in_ready  output  1  queue accepts a word this cycle
- in_inst  input  32  instruction word
- in_pc  input  PC_WIDTH  PC tag of in_inst
- out_valid  output  1  head entry is valid
- out_ready  input  1  consumer takes the head entry this cycle
- out_pc  output  PC_WIDTH  PC tag of the head entry
- out_opcode  output  6  inst[31:26]
- out_rs  output  5  inst[25:21]
- out_rt  output  5  inst[20:16]
- out_rd  output  5  inst[15:11]
- out_shamt  output  5  inst[10:6]
- out_funct  output  6  inst[5:0]
- out_imm16  output  16  inst[15:0]
- out_jt  output  26  inst[25:0]
- out_imm_ext  output  32  extended immediate
- out_class  output  2  0=R, 1=J, 2=I, 3 unused
- count  output  $clog2(DEPTH)+1  occupied entries
- perf_issued  output  32  instructions popped (optional feature)
- perf_rtype  output  32  R-type instructions popped (optional feature)

Behaviour:
- Reset (async, active-high): queue empty, pointers 0, count=0, out_valid=0, in_ready=1, all out_* data outputs 0, perf counters 0.
- Push happens when in_valid && in_ready. Pop happens when out_valid && out_ready.
- in_ready = (count != DEPTH). It is computed from registered state only and does not depend on out_ready in the same cycle, so a push into a full queue is never accepted even while a pop occurs.
- out_valid = (count != 0). out_* always reflect the head entry. Data outputs hold their last value when empty; the value is don't-care, but it must not be X after reset.
- Decode is combinational on the input side, and the decoded record is written into the FIFO.
- Latency: a word pushed at edge N is visible at out_* after edge N, i.e. in the cycle after the push. There is no same-cycle bypass.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Class decoding:
  - opcode 0x00 -> R.
  - opcode 0x02 or 0x03 -> J.
  - all other opcodes -> I.
- Immediate extension:
  - opcode 0x0C/0x0D/0x0E (ANDI/ORI/XORI) -> zero-extend imm16.
  - opcode 0x0F (LUI) -> {imm16, 16'h0}.
  - all other opcodes -> sign-extend imm16.
  - For R and J classes, out_imm_ext uses the sign-extend rule (don't-care to consumers).
- flush asserted at an edge: count=0 and both pointers = 0. Any push or pop in that cycle is discarded, so flush has priority. out_valid=0 and in_ready=1 in the following cycle.
- reset asserted mid-operation: immediate return to the reset state without waiting for a clock edge.

Optional Feature:
- Macro: INST_DECODE_QUEUE_PERF_EN.
- With the macro defined:
  - perf_issued increments by 1 on every pop.
  - perf_rtype also increments on every pop whose out_class=0.
  - Both counters wrap at 2^32, reset to 0, and are not cleared by flush.
- Without the macro: no counter registers are built, and perf_issued and perf_rtype are tied to 0. The port list is identical in both builds.

Test Plan:
- Reset, then push 0x012A4020 with pc=0x00400000 and out_ready=1 -> the next cycle shows out_valid=1, opcode=0, rs=9, rt=10, rd=8, shamt=0, funct=0x20, class=0, out_pc=0x00400000.
- Push 0x2008FFFF (ADDI) -> imm16=0xFFFF, imm_ext=0xFFFFFFFF, rt=8, class=2. Push 0x3508FFFF (ORI) -> imm_ext=0x0000FFFF. Push 0x3C011234 (LUI) -> imm_ext=0x12340000.
- Push 0x0C100000 (JAL) -> class=1, jt=0x0100000, opcode=3.
- Hold out_ready=0 and push DEPTH=4 words -> count=4, in_ready=0, and a 5th in_valid is ignored. Then assert out_ready=1 and in_valid=1 continuously -> words pop in FIFO order, count stays between 3 and 4, and pointers wrap with no loss or duplication.
- With count=3, assert flush, in_valid and out_ready together -> the next cycle shows count=0, out_valid=0, in_ready=1, and the flushed-cycle word never appears at the output.
- Build with INST_DECODE_QUEUE_PERF_EN and pop 5 words (2 R-type) -> perf_issued=5, perf_rtype=2, both unchanged by a flush. Build without the macro -> both read 0.
